// File: rtl/ram_pkg.sv
// Shared types for the simple-dual-port RAM and its read pipeline.
package ram_pkg;

  // Which value a read sees when it hits the word being written in the same cycle.
  typedef enum logic {
    RDW_WRITE_FIRST,
    RDW_READ_FIRST
  } rdw_mode_e;

  // Init sequencer states: zero-filling the array, or open for access.
  typedef enum logic {
    ST_INIT,
    ST_READY
  } ram_state_e;

  // Widen a per-byte lane mask into a per-bit mask.
  function automatic logic [63:0] lane_to_bits(input logic [7:0] lanes,
                                              input int unsigned byte_w);
    logic [63:0] bits;
    bits = '0;
    for (int i = 0; i < 64; i++) begin
      if ((i / byte_w) < 8) bits[i] = lanes[i / byte_w];
    end
    return bits;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-side pipeline: carries the sampled word and its valid flag for
// RD_LATENCY stages. Each data stage reloads only when a valid word
// arrives, so the output holds its last read between transactions.
module ram_rd_pipe #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_vld,
  output logic signed [DATA_WIDTH-1:0] out_data
);

  logic                         vld_p_q  [RD_LATENCY];
  logic                         vld_p_d  [RD_LATENCY];
  logic signed [DATA_WIDTH-1:0] data_p_q [RD_LATENCY];
  logic signed [DATA_WIDTH-1:0] data_p_d [RD_LATENCY];

  // Next-stage values: valid always shifts, data shifts only with valid.
  always_comb begin
    vld_p_d[0]  = in_vld;
    data_p_d[0] = in_vld ? in_data : data_p_q[0];
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_p_d[i]  = vld_p_q[i-1];
      data_p_d[i] = vld_p_q[i-1] ? data_p_q[i-1] : data_p_q[i];
    end
  end

  // Stage registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_p_q[i]  <= 1'b0;
        data_p_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_p_q[i]  <= vld_p_d[i];
        data_p_q[i] <= data_p_d[i];
      end
    end
  end

  assign out_vld  = vld_p_q[RD_LATENCY-1];
  assign out_data = data_p_q[RD_LATENCY-1];

endmodule

// File: rtl/ram_dp.sv
// Simple-dual-port RAM: one byte-masked write port and one read port on a
// single clock, selectable read-during-write policy, and a zero-fill
// sequencer that gates both ports until the array is initialised.
module ram_dp
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned MEM_SIZE      = 1024,
  parameter int unsigned ADDR_WIDTH    = (MEM_SIZE == 1) ? 1 : $clog2(MEM_SIZE),
  parameter int unsigned BYTE_WIDTH    = 8,
  parameter int unsigned RD_LATENCY    = 1,
  parameter rdw_mode_e   RDW_MODE      = RDW_WRITE_FIRST,
  parameter int unsigned INIT_ON_RESET = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  output logic                                 ready,
  input  logic                                 wr_en,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic signed [DATA_WIDTH-1:0]         wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]     wr_mask,
  input  logic                                 rd_en,
  input  logic [ADDR_WIDTH-1:0]                rd_addr,
  output logic signed [DATA_WIDTH-1:0]         rd_data,
  output logic                                 rd_valid
);

  localparam int unsigned MASK_WIDTH = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;

`ifdef FPGA
  (* ram_style = "block" *)
`endif
  logic signed [DATA_WIDTH-1:0] mem [MEM_SIZE];

  logic                         wr_fire;
  logic                         rd_fire;
  logic [ADDR_WIDTH-1:0]        wr_idx;
  logic [ADDR_WIDTH-1:0]        rd_idx;
  logic [DATA_WIDTH-1:0]        wr_bits;
  logic signed [DATA_WIDTH-1:0] rd_word;
  logic signed [DATA_WIDTH-1:0] rd_sample;

  // A single-word array has no meaningful address bit.
  function automatic logic [ADDR_WIDTH-1:0] map_addr(input logic [ADDR_WIDTH-1:0] a);
    if (MEM_SIZE == 1) return '0;
    return a;
  endfunction

  // Lane-wise merge of new data over an old word.
  function automatic logic signed [DATA_WIDTH-1:0] merge_word(
    input logic signed [DATA_WIDTH-1:0] old_w,
    input logic signed [DATA_WIDTH-1:0] new_w,
    input logic [DATA_WIDTH-1:0]        bits);
    return (new_w & bits) | (old_w & ~bits);
  endfunction

  assign ready   = (state_q == ST_READY);
  assign wr_fire = ready && wr_en;
  assign rd_fire = ready && rd_en;
  assign wr_idx  = map_addr(wr_addr);
  assign rd_idx  = map_addr(rd_addr);
  assign wr_bits = DATA_WIDTH'(lane_to_bits(8'(wr_mask), BYTE_WIDTH));
  assign rd_word = mem[rd_idx];

  // Bypass mux outside the array: write-first reads see the merged word.
  always_comb begin
    rd_sample = rd_word;
    if (RDW_MODE == RDW_WRITE_FIRST && wr_fire && (wr_idx == rd_idx)) begin
      rd_sample = merge_word(rd_word, wr_data, wr_bits);
    end
  end

  // Init sequencer next state: clear restarts from address 0 in any state.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (clear) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
    end else if (state_q == ST_INIT) begin
      if (init_cnt_q == LAST_ADDR) begin
        state_d    = ST_READY;
        init_cnt_d = '0;
      end else begin
        init_cnt_d = init_cnt_q + 1'b1;
      end
    end
  end

  // Sequencer registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (INIT_ON_RESET != 0) state_q <= ST_INIT;
      else                    state_q <= ST_READY;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Array write port: zero-fill during init, otherwise byte-masked user write.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[init_cnt_q] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < MASK_WIDTH; i++) begin
        if (wr_mask[i]) mem[wr_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_fire),
    .in_data  (rd_sample),
    .out_vld  (rd_valid),
    .out_data (rd_data)
  );

endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp: two instances share stimulus, one write-first with
// single-cycle reads, one read-first with two-cycle reads.
module tb_ram_dp;
  import ram_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               clear;
  logic               wr_en;
  logic [3:0]         wr_addr;
  logic signed [15:0] wr_data;
  logic [1:0]         wr_mask;
  logic               rd_en;
  logic [3:0]         rd_addr;

  logic               ready_a, ready_b;
  logic               rd_valid_a, rd_valid_b;
  logic signed [15:0] rd_data_a, rd_data_b;

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] ref_mem [16];

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [1:0]  mask;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  ram_dp #(.DATA_WIDTH(16), .MEM_SIZE(16), .BYTE_WIDTH(8), .RD_LATENCY(1),
           .RDW_MODE(RDW_WRITE_FIRST), .INIT_ON_RESET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a));

  ram_dp #(.DATA_WIDTH(16), .MEM_SIZE(16), .BYTE_WIDTH(8), .RD_LATENCY(2),
           .RDW_MODE(RDW_READ_FIRST), .INIT_ON_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = 16'h0000;
  endtask

  task automatic apply_ref(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    if (m[0]) ref_mem[a][7:0]  = d[7:0];
    if (m[1]) ref_mem[a][15:8] = d[15:8];
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] m);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    apply_ref(a, d, m);
    tick();
    wr_en = 1'b0; wr_mask = 2'b00;
  endtask

  // One read: A must answer after 1 edge, B after exactly 2.
  task automatic do_read(input logic [3:0] a, input logic [15:0] exp, input string nm);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk($sformatf("%s a_vld_l1", nm), 16'(rd_valid_a), 16'd1);
    chk($sformatf("%s a_data", nm), rd_data_a, exp);
    chk($sformatf("%s b_vld_l1", nm), 16'(rd_valid_b), 16'd0);
    tick();
    chk($sformatf("%s a_vld_l2", nm), 16'(rd_valid_a), 16'd0);
    chk($sformatf("%s b_vld_l2", nm), 16'(rd_valid_b), 16'd1);
    chk($sformatf("%s b_data", nm), rd_data_b, exp);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk($sformatf("%s ready_a", nm), 16'(ready_a), 16'd0);
    chk($sformatf("%s ready_b", nm), 16'(ready_b), 16'd0);
    chk($sformatf("%s vld_a", nm), 16'(rd_valid_a), 16'd0);
    chk($sformatf("%s vld_b", nm), 16'(rd_valid_b), 16'd0);
    chk($sformatf("%s data_a", nm), rd_data_a, 16'h0000);
    chk($sformatf("%s data_b", nm), rd_data_b, 16'h0000);
  endtask

  // Count n edges of init; ready must rise on the last one only.
  task automatic chk_init(input string nm, input int n);
    for (int e = 1; e <= n; e++) begin
      tick();
      chk($sformatf("%s ready_a e%0d", nm, e), 16'(ready_a), 16'(e == n));
      chk($sformatf("%s ready_b e%0d", nm, e), 16'(ready_b), 16'(e == n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_s [64];

    tbl[0] = '{4'd5,  16'hABCD, 2'b11, 16'hABCD};
    tbl[1] = '{4'd5,  16'h1234, 2'b01, 16'hAB34};
    tbl[2] = '{4'd7,  16'hFFFF, 2'b10, 16'hFF00};
    tbl[3] = '{4'd7,  16'h0055, 2'b01, 16'hFF55};
    tbl[4] = '{4'd2,  16'h8000, 2'b11, 16'h8000};
    tbl[5] = '{4'd2,  16'h0000, 2'b00, 16'h8000};
    tbl[6] = '{4'd15, 16'h7E81, 2'b10, 16'h7E00};

    rst_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    wr_mask = '0; rd_en = 1'b0; rd_addr = '0;
    tick(); tick();
    chk_reset_outs("reset");

    // Release reset; hammer both ports during init, nothing may take effect.
    rst_n = 1'b1;
    rd_en = 1'b1; rd_addr = 4'd0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF; wr_mask = 2'b11;
    for (int e = 1; e <= 16; e++) begin
      tick();
      chk($sformatf("init ready_a e%0d", e), 16'(ready_a), 16'(e == 16));
      chk($sformatf("init ready_b e%0d", e), 16'(ready_b), 16'(e == 16));
      chk($sformatf("init vld_a e%0d", e), 16'(rd_valid_a), 16'd0);
      chk($sformatf("init vld_b e%0d", e), 16'(rd_valid_b), 16'd0);
    end
    rd_en = 1'b0; wr_en = 1'b0; wr_mask = 2'b00;
    tick();
    chk("init vld_b tail", 16'(rd_valid_b), 16'd0);
    zero_ref();

    for (int a = 0; a < 16; a++) do_read(4'(a), 16'h0000, $sformatf("zero[%0d]", a));

    for (int i = 0; i < 7; i++) begin
      do_write(tbl[i].addr, tbl[i].data, tbl[i].mask);
      do_read(tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));
    end

    // Read-during-write on addr 3.
    do_write(4'd3, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h2222; wr_mask = 2'b10;
    rd_en = 1'b1; rd_addr = 4'd3;
    apply_ref(4'd3, 16'h2222, 2'b10);
    tick();
    wr_en = 1'b0; wr_mask = 2'b00; rd_en = 1'b0;
    chk("rdw a_vld", 16'(rd_valid_a), 16'd1);
    chk("rdw write_first", rd_data_a, 16'h2211);
    tick();
    chk("rdw b_vld", 16'(rd_valid_b), 16'd1);
    chk("rdw read_first", rd_data_b, 16'h1111);
    do_read(4'd3, 16'h2211, "rdw after");

    // Streaming: 64 back-to-back reads with writes to other addresses.
    for (int k = 0; k < 66; k++) begin
      if (k < 64) begin
        logic [15:0] d;
        logic [1:0]  m;
        d = 16'($urandom);
        m = 2'($urandom_range(0, 3));
        rd_en = 1'b1; rd_addr = 4'(k % 16);
        exp_s[k] = ref_mem[k % 16];
        wr_en = 1'b1; wr_addr = 4'((k + 8) % 16); wr_data = d; wr_mask = m;
        apply_ref(4'((k + 8) % 16), d, m);
      end else begin
        rd_en = 1'b0; wr_en = 1'b0; wr_mask = 2'b00;
      end
      tick();
      chk($sformatf("stream a_vld k%0d", k), 16'(rd_valid_a), 16'(k < 64));
      if (k < 64) chk($sformatf("stream a_data k%0d", k), rd_data_a, exp_s[k]);
      chk($sformatf("stream b_vld k%0d", k), 16'(rd_valid_b), 16'(k >= 1 && k <= 64));
      if (k >= 1 && k <= 64) chk($sformatf("stream b_data k%0d", k), rd_data_b, exp_s[k-1]);
    end
    rd_en = 1'b0; wr_en = 1'b0; wr_mask = 2'b00;

    // Clear with a read in flight.
    do_write(4'd9, 16'h7FFF, 2'b11);
    rd_en = 1'b1; rd_addr = 4'd9;
    tick();
    rd_en = 1'b0; clear = 1'b1;
    chk("clr a_vld", 16'(rd_valid_a), 16'd1);
    chk("clr a_data", rd_data_a, 16'h7FFF);
    tick();
    clear = 1'b0;
    chk("clr ready_a", 16'(ready_a), 16'd0);
    chk("clr a_vld_off", 16'(rd_valid_a), 16'd0);
    chk("clr a_hold", rd_data_a, 16'h7FFF);
    chk("clr b_vld", 16'(rd_valid_b), 16'd1);
    chk("clr b_data", rd_data_b, 16'h7FFF);
    chk_init("clr", 16);
    zero_ref();
    do_read(4'd9, 16'h0000, "clr rd9");

    // Clear again mid-init restarts the count.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    chk("clr2 ready_a", 16'(ready_a), 16'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk_init("clr2", 16);

    // Reset mid-init.
    do_write(4'd12, 16'h5A5A, 2'b11);
    do_read(4'd12, 16'h5A5A, "pre_rst");
    rst_n = 1'b0; #1;
    chk_reset_outs("rst_async");
    tick(); tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
    chk("mid ready_a", 16'(ready_a), 16'd0);
    rst_n = 1'b0; #1;
    chk_reset_outs("rst_mid");
    tick();
    rst_n = 1'b1;
    chk_init("rst_reinit", 16);
    zero_ref();
    do_read(4'd12, 16'h0000, "post_rst12");
    do_read(4'd15, 16'h0000, "post_rst15");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
